// File: rtl/alu_seq.sv
// Sequential ALU. Logic ops and add/sub finish in one cycle. Shifts step one
// bit per cycle through an internal register before the result is presented.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [1:0]       dbg_state
);

    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
    localparam logic [SHW-1:0] CNT_ZERO = '0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    logic [1:0]       state;
    logic [WIDTH-1:0] y_q;
    logic             c_q;
    logic             v_q;
    logic [WIDTH-1:0] sh_q;
    logic [SHW-1:0]   cnt_q;
    logic             dir_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res_y;
    logic             res_c;
    logic             res_v;
    logic [SHW-1:0]   amt;
    logic             shift_start;
    logic [WIDTH-1:0] sh_next;

    // Handshake: a request transfers on a rising edge with in_valid & in_ready;
    // a result transfers on a rising edge with out_valid & out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    assign y     = y_q;
    assign c_out = c_q;
    assign ovf   = v_q;
    assign zero  = (y_q == '0);
    assign neg   = y_q[MSB];

    assign amt         = b[SHW-1:0];
    assign shift_start = sel[2] & sel[1] & (amt != CNT_ZERO);
    assign sh_next     = dir_q ? (sh_q >> 1) : (sh_q << 1);

    // Single-cycle result; a zero-amount shift passes A straight through.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        res_y = a;
        res_c = 1'b0;
        res_v = 1'b0;
        case (sel)
            OP_ADD: begin
                res_y = sum[MSB:0];
                res_c = sum[WIDTH];
                res_v = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res_y = diff[MSB:0];
                res_c = diff[WIDTH];
                res_v = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);
            end
            OP_AND:  res_y = a & b;
            OP_OR:   res_y = a | b;
            OP_XOR:  res_y = a ^ b;
            OP_NOT:  res_y = ~a;
            default: res_y = a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            y_q   <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            sh_q  <= '0;
            cnt_q <= '0;
            dir_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (shift_start) begin
                            sh_q  <= a;
                            cnt_q <= amt;
                            dir_q <= sel[0];
                            state <= SHIFT;
                        end else begin
                            y_q   <= res_y;
                            c_q   <= res_c;
                            v_q   <= res_v;
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_next;
                    cnt_q <= cnt_q - CNT_ONE;
                    // The edge that applies the final bit also publishes it.
                    if (cnt_q == CNT_ONE || cnt_q == CNT_ZERO) begin
                        y_q   <= sh_next;
                        c_q   <= 1'b0;
                        v_q   <= 1'b0;
                        cnt_q <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): a latency/result model checked every
// cycle plus literal expectations for each directed vector.
module tb_alu_seq;

    localparam int W = 8;

    localparam int P_IDLE = 0;
    localparam int P_BUSY = 1;
    localparam int P_DONE = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         c_out;
    logic         ovf;
    logic         zero;
    logic         neg;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected results as {y, c_out, ovf}, pushed when a request is accepted.
    logic [W+1:0] exp_q[$];
    logic [W+1:0] cur;
    logic         have_cur;
    int           m_phase;
    int           m_cnt;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic [2:0] rs);
        int ua, ub, sa, sb, r, n;
        logic [W-1:0] ry;
        logic rc, rv;
        ua = int'(ra);
        ub = int'(rb);
        sa = ra[W-1] ? ua - 256 : ua;
        sb = rb[W-1] ? ub - 256 : ub;
        n  = int'(rb[2:0]);
        r  = 0;
        ry = '0;
        rc = 1'b0;
        rv = 1'b0;
        case (rs)
            3'd0: begin
                r  = ua + ub;
                ry = r[W-1:0];
                rc = (r > 255);
                rv = (sa + sb > 127) || (sa + sb < -128);
            end
            3'd1: begin
                r  = ua - ub;
                ry = r[W-1:0];
                rc = (ua < ub);
                rv = (sa - sb > 127) || (sa - sb < -128);
            end
            3'd2: ry = ra & rb;
            3'd3: ry = ra | rb;
            3'd4: ry = ra ^ rb;
            3'd5: ry = ~ra;
            3'd6: begin
                r  = ua << n;
                ry = r[W-1:0];
            end
            default: ry = ra >> n;
        endcase
        return {ry, rc, rv};
    endfunction

    function automatic int ref_lat(input logic [W-1:0] rb, input logic [2:0] rs);
        return (rs[2:1] == 2'b11) ? int'(rb[2:0]) + 1 : 1;
    endfunction

    // Model: a request occupies the block for ref_lat cycles, then the result
    // is held until taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE;
            m_cnt   <= 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (in_valid) begin
                        exp_q.push_back(ref_op(a, b, sel));
                        m_cnt   <= ref_lat(b, sel) - 1;
                        m_phase <= (ref_lat(b, sel) == 1) ? P_DONE : P_BUSY;
                    end
                end
                P_BUSY: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) m_phase <= P_DONE;
                end
                default: begin
                    if (out_ready) m_phase <= P_IDLE;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            have_cur = 1'b0;
        end else begin
            check("in_ready", in_ready, m_phase == P_IDLE);
            check("out_valid", out_valid, m_phase == P_DONE);
            if (m_phase == P_DONE) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard: result presented with empty queue at %0t", $time);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    have_cur = 1'b1;
                end
                check("model_y", y, cur[W+1:2]);
                check("model_c", c_out, cur[1]);
                check("model_ovf", ovf, cur[0]);
                check("model_zero", zero, cur[W+1:2] == '0);
                check("model_neg", neg, cur[W+1]);
            end else begin
                have_cur = 1'b0;
            end
        end
    end

    task automatic junk_inputs();
        in_valid = 1'($urandom_range(0, 1));
        a        = 8'($urandom_range(0, 255));
        b        = 8'($urandom_range(0, 255));
        sel      = 3'($urandom_range(0, 7));
    endtask

    // Issue one request, measure latency, hold the result for `hold` cycles
    // while scrambling the inputs, then release it.
    task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [2:0] ts, input logic [7:0] ey, input logic ec,
                          input logic ev, input int elat, input int hold);
        int cyc;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        sel      = ts;
        @(posedge clk);
        #1;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            junk_inputs();
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!out_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no out_valid required within %0d cycles", name, elat);
        end else begin
            check({name, "_lat"}, cyc + 1, elat);
            check({name, "_y"}, y, ey);
            check({name, "_c"}, c_out, ec);
            check({name, "_ovf"}, ovf, ev);
            check({name, "_zero"}, zero, ey == 8'h00);
            check({name, "_neg"}, neg, ey[7]);
        end
        for (int i = 0; i < hold; i++) begin
            junk_inputs();
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            check({name, "_hold_valid"}, out_valid, 1'b1);
            check({name, "_hold_y"}, y, ey);
            check({name, "_hold_c"}, c_out, ec);
            check({name, "_hold_ovf"}, ovf, ev);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, "_idle"}, in_ready, 1'b1);
        check({name, "_released"}, out_valid, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sel       = '0;
        #3;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, 8'h00);
        check("rst_c", c_out, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_zero", zero, 1'b1);
        check("rst_neg", neg, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add_carry", 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1, 1'b0, 1, 0);
        run_op("add_ovf",   8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b1, 1, 0);
        run_op("sub_ovf",   8'h80, 8'h01, 3'b001, 8'h7F, 1'b0, 1'b1, 1, 0);
        run_op("sub_borrow", 8'h03, 8'h05, 3'b001, 8'hFE, 1'b1, 1'b0, 1, 2);
        run_op("and",       8'hC3, 8'h5A, 3'b010, 8'h42, 1'b0, 1'b0, 1, 0);
        run_op("or",        8'hC3, 8'h5A, 3'b011, 8'hDB, 1'b0, 1'b0, 1, 0);
        run_op("xor_zero",  8'h5A, 8'h5A, 3'b100, 8'h00, 1'b0, 1'b0, 1, 0);
        run_op("not",       8'h0F, 8'h00, 3'b101, 8'hF0, 1'b0, 1'b0, 1, 0);
        run_op("shl3",      8'h81, 8'h03, 3'b110, 8'h08, 1'b0, 1'b0, 4, 0);
        run_op("shr3",      8'h81, 8'h03, 3'b111, 8'h10, 1'b0, 1'b0, 4, 0);
        run_op("shl0",      8'h81, 8'h00, 3'b110, 8'h81, 1'b0, 1'b0, 1, 0);
        run_op("shr7",      8'h80, 8'h07, 3'b111, 8'h01, 1'b0, 1'b0, 8, 0);
        run_op("shl_upper_b", 8'h01, 8'hF9, 3'b110, 8'h02, 1'b0, 1'b0, 2, 0);
        run_op("backpress", 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1, 1'b0, 1, 5);
        run_op("bp_shift",  8'h81, 8'h03, 3'b110, 8'h08, 1'b0, 1'b0, 4, 5);

        // Reset two cycles into a 6-bit shift.
        in_valid = 1'b1;
        a        = 8'h3C;
        b        = 8'h06;
        sel      = 3'b110;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_y", y, 8'h00);
        check("midrst_c", c_out, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        check("midrst_zero", zero, 1'b1);
        check("midrst_neg", neg, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_result", out_valid, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        run_op("after_rst", 8'hC0, 8'h06, 3'b111, 8'h03, 1'b0, 1'b0, 7, 1);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand and result width (legal values 4..32).
REQ-002 The module SHALL have parameter SHW, default $clog2(WIDTH), shift-amount field width.
REQ-003 The module SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid  input  1  operation request present.
REQ-006 The module SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The module SHALL have port a  input  WIDTH  operand A.
REQ-008 The module SHALL have port b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
REQ-009 The module SHALL have port sel  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl, 111 shr (logical).
REQ-010 The module SHALL have port out_valid  output  1  result held on y/flags.
REQ-011 The module SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 The module SHALL have port y  output  WIDTH  result.
REQ-013 The module SHALL have port c_out  output  1  carry (add) or borrow (sub); 0 for other ops.
REQ-014 The module SHALL have port ovf  output  1  signed two's-complement overflow (add/sub); 0 for other ops.
REQ-015 The module SHALL have port zero  output  1  high when y == 0.
REQ-016 The module SHALL have port neg  output  1  equal to y[WIDTH-1].

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 A request SHALL be accepted on a rising edge where in_valid & in_ready; a, b, sel are captured at that edge and later input changes SHALL NOT affect the result.
REQ-019 For ops 000-101, acceptance SHALL move IDLE->DONE with y and flags registered at that edge (out_valid one cycle after acceptance).
REQ-020 For shifts with amount n > 0, acceptance SHALL load A into an internal register and a counter with n, move to SHIFT, shift one bit per cycle, and move SHIFT->DONE on the edge that applies the last bit; out_valid rises n+1 cycles after acceptance.
REQ-021 A shift with n = 0 SHALL go IDLE->DONE directly with y = A.
REQ-022 shl SHALL fill zeros at the LSB, shr SHALL fill zeros at the MSB; n >= WIDTH is impossible by field width; non-power-of-2 WIDTH with n >= WIDTH SHALL yield y = 0.
REQ-023 Add SHALL compute {c_out,y} = a + b in WIDTH+1 bits; ovf = (a[MSB]==b[MSB]) & (y[MSB]!=a[MSB]).
REQ-024 Sub SHALL compute y = a - b mod 2^WIDTH; c_out = 1 iff a < b unsigned; ovf = (a[MSB]!=b[MSB]) & (y[MSB]!=a[MSB]).
REQ-025 In DONE, y and all flags SHALL hold stable while out_ready = 0; DONE->IDLE SHALL occur on an edge with out_ready = 1.
REQ-026 in_valid asserted outside IDLE SHALL be ignored (no capture, no state change); no new request is accepted in the DONE->IDLE cycle.
REQ-027 Illegal states SHALL recover to IDLE on the next edge with out_valid = 0.

Reset
REQ-028 rst_n = 0 SHALL immediately (without clk) force state IDLE, in_ready = 1 (once rst_n released, in_ready reflects IDLE), out_valid = 0, y = 0, c_out = 0, ovf = 0, zero = 1, neg = 0, shift counter = 0.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no result SHALL be presented after release.

Verification (WIDTH=8)
REQ-030 Add: a=0xF0, b=0x20, sel=000 -> next cycle out_valid=1, y=0x10, c_out=1, ovf=0, zero=0, neg=0.
REQ-031 Sub overflow: a=0x80, b=0x01, sel=001 -> y=0x7F, c_out=0, ovf=1, neg=0; a=0x03, b=0x05 -> y=0xFE, c_out=1, neg=1.
REQ-032 Shift latency: a=0x81, b=0x03, sel=110 -> in_ready low 4 cycles, out_valid 4 cycles after accept, y=0x08; sel=111, same operands -> y=0x10; b=0x00 -> y=0x81 after 1 cycle.
REQ-033 Backpressure: result held with out_ready=0 for 5 cycles while a/b/sel/in_valid toggle -> y and flags unchanged, no second capture; out_ready=1 -> IDLE next cycle.
REQ-034 Zero/logic: a=0x5A, b=0x5A, sel=100 -> y=0x00, zero=1, c_out=0, ovf=0; sel=101 with a=0x0F -> y=0xF0, neg=1.
REQ-035 Reset mid-shift: rst_n low 2 cycles into a 6-bit shift -> outputs at reset values asynchronously, out_valid stays 0 after release, next request completes normally.
